pmem_line_responder: RTL and testbench
======================================

// Module: pmem_line_responder
// PURPOSE
//  Memory-side responder for the cache pmem line interface; services line reads/writes issued by l2 cache.
//  Accepts one whole-line request; moves it as BEATS narrow beats over a command/beat DRAM-style bus.
//  Returns the assembled line with a single-cycle pmem_resp. Keeps saturating read/write transaction counts.
// PARAMETERS
//  LINE_W   128  pmem line width in bits (matches lc3b_pmem_line)
//  BEAT_W   32   downstream beat width; LINE_W % BEAT_W == 0
//  BEATS    LINE_W/BEAT_W (4)  beats per line; derived, not overridden
// PORTS
//  clk              in   1       single clock, all state on rising edge
//  reset_n          in   1       asynchronous, active-low reset
//  pmem_read        in   1       line read request, held until pmem_resp
//  pmem_write       in   1       line write request, held until pmem_resp
//  pmem_address     in   16      byte address; low log2(LINE_W/8) bits ignored
//  pmem_wdata       in   LINE_W  write line, valid with pmem_write
//  pmem_resp        out  1       one-cycle completion pulse
//  pmem_rdata       out  LINE_W  last line read; valid in resp cycle and held after
//  dram_cmd_valid   out  1       command valid
//  dram_cmd_ready   in   1       command accepted when valid&ready
//  dram_cmd_write   out  1       1=write line, 0=read line
//  dram_cmd_addr    out  16      line-aligned address (low bits zero)
//  dram_wbeat_valid out  1       write beat valid
//  dram_wbeat_ready in   1       write beat accepted when valid&ready
//  dram_wbeat       out  BEAT_W  write beat data
//  dram_rbeat_valid in   1       read beat present (no backpressure)
//  dram_rbeat       in   BEAT_W  read beat data
//  read_count       out  16      completed reads, saturates at 16'hFFFF
//  write_count      out  16      completed writes, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; all outputs 0; line buffer, counters, beat index cleared.
//  FSM IDLE -> CMD -> (WDATA | RDATA) -> RESP -> IDLE.
//  IDLE: pmem_read|pmem_write -> latch aligned addr, op, pmem_wdata; go CMD. Both high -> write wins.
//  CMD: dram_cmd_valid=1, addr/write from latch; on ready -> WDATA/RDATA, beat index=0.
//  WDATA: dram_wbeat = latched_line[idx*BEAT_W +: BEAT_W] (beat 0 = bits BEAT_W-1:0);
//    valid held until ready; idx++ per accept; accept at idx==BEATS-1 -> RESP.
//  RDATA: each rbeat_valid writes rdata slot idx, idx++; beat at idx==BEATS-1 -> RESP.
//  RESP: pmem_resp=1 exactly one cycle; matching counter +1 (saturating); -> IDLE.
//  IDLE accepts a new request the cycle after RESP (back-to-back writeback+fill legal).
//  Min latency, ready/valid always 1: request sampled cycle 0, pmem_resp in cycle 6 (read and write).
//  pmem_rdata registered; changes only in RDATA beats; writes never modify it.
//  Request inputs sampled only in IDLE; mid-transaction changes/deassertion ignored, txn completes.
//  dram_rbeat_valid outside RDATA ignored. Beat index wraps to 0 on leaving data state.
//  Reset mid-transaction: aborts immediately, no pmem_resp; downstream shares reset domain.
//  Counter at 16'hFFFF stays there; other counter unaffected.
// STRUCTURE
//  lc3b_types: add lc3b_dram_beat (logic [BEAT_W-1:0]), lc3b_beat_idx, enum lc3b_pmem_resp_state.
//  Reuse lc3b_pmem_line, lc3b_word. Sub-module pmem_line_buffer: line register with
//  per-beat slot write/select. Top holds FSM, latches, counters.
// TESTING
//  Read 16'h1234, rbeats 1,2,3,4 back-to-back -> cmd_addr 16'h1230 write=0;
//    resp cycle 6; rdata=128'h00000004_00000003_00000002_00000001.
//  Write 16'h0040, wdata 128'hDDDD..._AAAA..., wbeat_ready=1 -> beats AAAA..,..,DDDD.. in order;
//    resp cycle 6; write_count=1; pmem_rdata unchanged.
//  cmd_ready low 3 cycles, wbeat_ready toggling -> valid/data held stable while stalled;
//    exactly 4 beats; one resp.
//  read+write high together -> write performed; stray rbeat_valid in IDLE -> rdata unchanged.
//  reset_n low during RDATA beat 2 -> outputs 0 immediately, no resp; next read completes.
//  Preload read_count=16'hFFFE, 3 reads -> 16'hFFFF, stays.

Source files
------------

// File: rtl/pmem_line_responder_pkg.sv
// Shared types and helpers for the pmem line responder.
// The memory side moves one whole cache line as a burst of narrow DRAM beats.
package pmem_line_responder_pkg;

   localparam int LINE_W_DEF = 128;
   localparam int BEAT_W_DEF = 32;
   localparam int BEATS_DEF  = LINE_W_DEF / BEAT_W_DEF;

   typedef logic [LINE_W_DEF-1:0]        lc3b_pmem_line;
   typedef logic [15:0]                  lc3b_word;
   typedef logic [BEAT_W_DEF-1:0]        lc3b_dram_beat;
   typedef logic [$clog2(BEATS_DEF)-1:0] lc3b_beat_idx;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_WDATA = 3'd2,
      ST_RDATA = 3'd3,
      ST_RESP  = 3'd4
   } lc3b_pmem_resp_state;

   // Clears the byte-offset bits so the address points at the start of a line.
   function automatic lc3b_word line_align(input lc3b_word addr, input int unsigned off_w);
      lc3b_word mask;
      mask = lc3b_word'((32'd1 << off_w) - 32'd1);
      return addr & ~mask;
   endfunction

   function automatic lc3b_word sat_inc(input lc3b_word cnt);
      if (cnt == 16'hFFFF) begin
         return cnt;
      end else begin
         return cnt + 16'd1;
      end
   endfunction

endpackage

// File: rtl/pmem_line_buffer.sv
// Read-line register: collects incoming DRAM beats into their slot of the line.
// Holds its contents between reads so the last fetched line stays visible.
module pmem_line_buffer
   import pmem_line_responder_pkg::*;
#(
   parameter int LINE_W = LINE_W_DEF,
   parameter int BEAT_W = BEAT_W_DEF,
   parameter int IDX_W  = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              slot_we,
   input  logic [IDX_W-1:0]  slot_idx,
   input  logic [BEAT_W-1:0] slot_data,
   output logic [LINE_W-1:0] line
);

   logic [LINE_W-1:0] line_r;

   // Per-beat slot write into the line register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line_r <= '0;
      end else if (slot_we) begin
         line_r[int'(slot_idx)*BEAT_W +: BEAT_W] <= slot_data;
      end else begin
         line_r <= line_r;
      end
   end

   assign line = line_r;

endmodule

// File: rtl/pmem_line_responder.sv
// Memory-side responder: turns a whole-line pmem read/write into a command
// plus a burst of beats on the DRAM bus, then pulses pmem_resp for one cycle.
module pmem_line_responder
   import pmem_line_responder_pkg::*;
#(
   parameter int LINE_W = LINE_W_DEF,
   parameter int BEAT_W = BEAT_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [15:0]       pmem_address,
   input  logic [LINE_W-1:0] pmem_wdata,
   output logic              pmem_resp,
   output logic [LINE_W-1:0] pmem_rdata,
   output logic              dram_cmd_valid,
   input  logic              dram_cmd_ready,
   output logic              dram_cmd_write,
   output logic [15:0]       dram_cmd_addr,
   output logic              dram_wbeat_valid,
   input  logic              dram_wbeat_ready,
   output logic [BEAT_W-1:0] dram_wbeat,
   input  logic              dram_rbeat_valid,
   input  logic [BEAT_W-1:0] dram_rbeat,
   output logic [15:0]       read_count,
   output logic [15:0]       write_count
);

   localparam int          BEATS    = LINE_W / BEAT_W;
   localparam int          IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned OFF_W    = $clog2(LINE_W / 8);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

   lc3b_pmem_resp_state state_r, next_state_s;
   logic [IDX_W-1:0]    idx_r, idx_next_s;
   logic                op_write_r, op_write_next_s;
   lc3b_word            addr_r, addr_next_s;
   logic [LINE_W-1:0]   wline_r, wline_next_s;
   logic                req_take_s;
   logic                rslot_we_s;

   logic                cmd_valid_s, cmd_write_s, wbeat_valid_s, resp_s;
   lc3b_word            cmd_addr_s;
   logic [BEAT_W-1:0]   wbeat_s;

   logic                cmd_valid_r, cmd_write_r, wbeat_valid_r, resp_r;
   lc3b_word            cmd_addr_r;
   logic [BEAT_W-1:0]   wbeat_r;
   lc3b_word            read_count_r, write_count_r;

   // Requests are only looked at while idle; write wins when both are raised.
   assign req_take_s = (state_r == ST_IDLE) && (pmem_read || pmem_write);

   // Next values of the request latches.
   always_comb begin
      op_write_next_s = op_write_r;
      addr_next_s     = addr_r;
      wline_next_s    = wline_r;
      if (req_take_s) begin
         op_write_next_s = pmem_write;
         addr_next_s     = line_align(pmem_address, OFF_W);
         wline_next_s    = pmem_wdata;
      end else begin
         op_write_next_s = op_write_r;
         addr_next_s     = addr_r;
         wline_next_s    = wline_r;
      end
   end

   // State, beat index and request latch registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         idx_r      <= '0;
         op_write_r <= 1'b0;
         addr_r     <= 16'h0000;
         wline_r    <= '0;
      end else begin
         state_r    <= next_state_s;
         idx_r      <= idx_next_s;
         op_write_r <= op_write_next_s;
         addr_r     <= addr_next_s;
         wline_r    <= wline_next_s;
      end
   end

   // Next-state and beat-index logic.
   always_comb begin
      next_state_s = state_r;
      idx_next_s   = idx_r;
      case (state_r)
         ST_IDLE: begin
            if (req_take_s) begin
               next_state_s = ST_CMD;
            end else begin
               next_state_s = ST_IDLE;
            end
            idx_next_s = '0;
         end
         ST_CMD: begin
            if (dram_cmd_ready) begin
               next_state_s = op_write_r ? ST_WDATA : ST_RDATA;
            end else begin
               next_state_s = ST_CMD;
            end
            idx_next_s = '0;
         end
         ST_WDATA: begin
            if (dram_wbeat_ready) begin
               if (idx_r == LAST_IDX) begin
                  next_state_s = ST_RESP;
                  idx_next_s   = '0;
               end else begin
                  next_state_s = ST_WDATA;
                  idx_next_s   = idx_r + IDX_W'(1);
               end
            end else begin
               next_state_s = ST_WDATA;
               idx_next_s   = idx_r;
            end
         end
         ST_RDATA: begin
            if (dram_rbeat_valid) begin
               if (idx_r == LAST_IDX) begin
                  next_state_s = ST_RESP;
                  idx_next_s   = '0;
               end else begin
                  next_state_s = ST_RDATA;
                  idx_next_s   = idx_r + IDX_W'(1);
               end
            end else begin
               next_state_s = ST_RDATA;
               idx_next_s   = idx_r;
            end
         end
         ST_RESP: begin
            next_state_s = ST_IDLE;
            idx_next_s   = '0;
         end
         default: begin
            next_state_s = ST_IDLE;
            idx_next_s   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so that they leave on flops.
   always_comb begin
      cmd_valid_s   = (next_state_s == ST_CMD);
      cmd_write_s   = 1'b0;
      cmd_addr_s    = 16'h0000;
      wbeat_valid_s = (next_state_s == ST_WDATA);
      wbeat_s       = '0;
      resp_s        = (next_state_s == ST_RESP);
      if (cmd_valid_s) begin
         cmd_write_s = op_write_next_s;
         cmd_addr_s  = addr_next_s;
      end else begin
         cmd_write_s = 1'b0;
         cmd_addr_s  = 16'h0000;
      end
      if (wbeat_valid_s) begin
         wbeat_s = wline_r[int'(idx_next_s)*BEAT_W +: BEAT_W];
      end else begin
         wbeat_s = '0;
      end
   end

   // Registered DRAM and pmem handshake outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_valid_r   <= 1'b0;
         cmd_write_r   <= 1'b0;
         cmd_addr_r    <= 16'h0000;
         wbeat_valid_r <= 1'b0;
         wbeat_r       <= '0;
         resp_r        <= 1'b0;
      end else begin
         cmd_valid_r   <= cmd_valid_s;
         cmd_write_r   <= cmd_write_s;
         cmd_addr_r    <= cmd_addr_s;
         wbeat_valid_r <= wbeat_valid_s;
         wbeat_r       <= wbeat_s;
         resp_r        <= resp_s;
      end
   end

   // Saturating completion counters, bumped together with the response pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         read_count_r  <= 16'h0000;
         write_count_r <= 16'h0000;
      end else if (resp_s) begin
         if (op_write_r) begin
            write_count_r <= sat_inc(write_count_r);
            read_count_r  <= read_count_r;
         end else begin
            read_count_r  <= sat_inc(read_count_r);
            write_count_r <= write_count_r;
         end
      end else begin
         read_count_r  <= read_count_r;
         write_count_r <= write_count_r;
      end
   end

   assign rslot_we_s = (state_r == ST_RDATA) && dram_rbeat_valid;

   pmem_line_buffer #(
      .LINE_W (LINE_W),
      .BEAT_W (BEAT_W),
      .IDX_W  (IDX_W)
   ) u_rline (
      .clk       (clk),
      .reset_n   (reset_n),
      .slot_we   (rslot_we_s),
      .slot_idx  (idx_r),
      .slot_data (dram_rbeat),
      .line      (pmem_rdata)
   );

   assign pmem_resp        = resp_r;
   assign dram_cmd_valid   = cmd_valid_r;
   assign dram_cmd_write   = cmd_write_r;
   assign dram_cmd_addr    = cmd_addr_r;
   assign dram_wbeat_valid = wbeat_valid_r;
   assign dram_wbeat       = wbeat_r;
   assign read_count       = read_count_r;
   assign write_count      = write_count_r;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: the bench plays the DRAM side and the l2 cache,
// predicting lines, beats, latency and counters from the transaction rules.
module tb_pmem_line_responder;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         pmem_read, pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic         pmem_resp;
   logic [127:0] pmem_rdata;
   logic         dram_cmd_valid, dram_cmd_ready, dram_cmd_write;
   logic [15:0]  dram_cmd_addr;
   logic         dram_wbeat_valid, dram_wbeat_ready;
   logic [31:0]  dram_wbeat;
   logic         rbeat_valid;
   logic [31:0]  rbeat;
   logic [15:0]  read_count, write_count;

   int checks   = 0;
   int failures = 0;

   logic [15:0]  m_rd_cnt, m_wr_cnt;
   logic [127:0] m_rdata;

   always #5 clk = ~clk;

   pmem_line_responder dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .pmem_read        (pmem_read),
      .pmem_write       (pmem_write),
      .pmem_address     (pmem_address),
      .pmem_wdata       (pmem_wdata),
      .pmem_resp        (pmem_resp),
      .pmem_rdata       (pmem_rdata),
      .dram_cmd_valid   (dram_cmd_valid),
      .dram_cmd_ready   (dram_cmd_ready),
      .dram_cmd_write   (dram_cmd_write),
      .dram_cmd_addr    (dram_cmd_addr),
      .dram_wbeat_valid (dram_wbeat_valid),
      .dram_wbeat_ready (dram_wbeat_ready),
      .dram_wbeat       (dram_wbeat),
      .dram_rbeat_valid (rbeat_valid),
      .dram_rbeat       (rbeat),
      .read_count       (read_count),
      .write_count      (write_count)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sat(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   task automatic idle_cycles(input int k, input bit stray);
      repeat (k) begin
         rbeat_valid = stray;
         rbeat       = $urandom;
         @(posedge clk); #1;
      end
      rbeat_valid = 1'b0;
   endtask

   // mode 0: always ready; 1: random stalls and mid-transaction input noise;
   // 2: command held off three cycles, write-beat ready toggling.
   task automatic run_txn(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [127:0] wd, input logic [127:0] rl, input int mode);
      bit exp_w, cmd_done, cmd_hs, got_cw, c_stall, w_stall, prev_cw;
      int n, resps, resp_n, cmds, beats_w, beats_r;
      logic [127:0] got_w;
      logic [15:0]  got_addr, prev_caddr;
      logic [31:0]  prev_wbeat;
      exp_w = wr; cmd_done = 0; got_cw = 0; c_stall = 0; w_stall = 0; prev_cw = 0;
      n = 0; resps = 0; resp_n = 0; cmds = 0; beats_w = 0; beats_r = 0;
      got_w = '0; got_addr = '0; prev_caddr = '0; prev_wbeat = '0;
      pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wd;
      while (resps == 0 && n < 300) begin
         if (c_stall) begin
            chk("cmd_valid_held", dram_cmd_valid, 1);
            chk("cmd_addr_held", dram_cmd_addr, prev_caddr);
            chk("cmd_write_held", dram_cmd_write, prev_cw);
         end
         if (w_stall) begin
            chk("wbeat_valid_held", dram_wbeat_valid, 1);
            chk("wbeat_held", dram_wbeat, prev_wbeat);
         end
         if (mode == 1 && n >= 1) begin
            pmem_address = 16'($urandom);
            pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
               pmem_read = 0; pmem_write = 0;
            end
         end
         case (mode)
            0:       begin dram_cmd_ready = 1; dram_wbeat_ready = 1; end
            1:       begin dram_cmd_ready = ($urandom_range(0, 2) != 0); dram_wbeat_ready = ($urandom_range(0, 2) != 0); end
            default: begin dram_cmd_ready = (n >= 4); dram_wbeat_ready = (n % 2 == 1); end
         endcase
         if (cmd_done && !exp_w && beats_r < 4) begin
            rbeat_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rbeat       = rl[beats_r*32 +: 32];
         end else begin
            rbeat_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            rbeat       = $urandom;
         end
         cmd_hs = dram_cmd_valid && dram_cmd_ready;
         if (cmd_hs) begin
            cmds++; got_addr = dram_cmd_addr; got_cw = dram_cmd_write;
         end
         if (dram_wbeat_valid && dram_wbeat_ready) begin
            if (beats_w < 4) got_w[beats_w*32 +: 32] = dram_wbeat;
            beats_w++;
         end
         if (cmd_done && !exp_w && beats_r < 4 && rbeat_valid) beats_r++;
         c_stall = dram_cmd_valid && !dram_cmd_ready; prev_caddr = dram_cmd_addr; prev_cw = dram_cmd_write;
         w_stall = dram_wbeat_valid && !dram_wbeat_ready; prev_wbeat = dram_wbeat;
         @(posedge clk); #1;
         n++;
         if (cmd_hs) cmd_done = 1;
         if (pmem_resp) begin
            resps++; resp_n = n;
         end
      end
      rbeat_valid = 1'b0;
      chk("resp_seen", resps, 1);
      chk("cmd_count", cmds, 1);
      chk("cmd_write", got_cw, exp_w);
      chk("cmd_addr", got_addr, addr & 16'hFFF0);
      if (exp_w) begin
         chk("wbeat_count", beats_w, 4);
         chk("wline", got_w, wd);
         m_wr_cnt = sat(m_wr_cnt);
      end else begin
         chk("wbeats_on_read", beats_w, 0);
         m_rd_cnt = sat(m_rd_cnt);
         m_rdata  = rl;
      end
      if (mode == 0) chk("latency", resp_n, 6);
      chk("rdata", pmem_rdata, m_rdata);
      chk("read_count", read_count, m_rd_cnt);
      chk("write_count", write_count, m_wr_cnt);
      pmem_read = 0; pmem_write = 0;
      @(posedge clk); #1;
      chk("resp_one_cycle", pmem_resp, 0);
      chk("no_extra_wbeat", dram_wbeat_valid, 0);
   endtask

   initial begin
      logic [127:0] rl, wd;
      bit rd, wr;
      reset_n = 0; pmem_read = 0; pmem_write = 0; pmem_address = '0; pmem_wdata = '0;
      dram_cmd_ready = 0; dram_wbeat_ready = 0; rbeat_valid = 0; rbeat = '0;
      m_rd_cnt = '0; m_wr_cnt = '0; m_rdata = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_resp", pmem_resp, 0);
      chk("rst_cmd_valid", dram_cmd_valid, 0);
      chk("rst_wbeat_valid", dram_wbeat_valid, 0);
      chk("rst_rdata", pmem_rdata, 0);
      chk("rst_counts", {read_count, write_count}, 0);
      @(negedge clk) reset_n = 1;
      @(posedge clk); #1;

      run_txn(1, 0, 16'h1234, '0, 128'h00000004_00000003_00000002_00000001, 0);
      run_txn(0, 1, 16'h0040, {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}, '0, 0);
      run_txn(0, 1, 16'h2a57, {$urandom, $urandom, $urandom, $urandom}, '0, 2);
      run_txn(1, 1, 16'h0ff3, {$urandom, $urandom, $urandom, $urandom}, {4{32'h5A5A0000}}, 0);

      idle_cycles(4, 1);
      chk("stray_rbeat_idle", pmem_rdata, m_rdata);

      // Abort a read while its third beat is on the bus.
      pmem_read = 1; pmem_address = 16'h0100; dram_cmd_ready = 1; rbeat_valid = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rbeat_valid = 1; rbeat = 32'h11;
      @(posedge clk); #1;
      rbeat = 32'h22;
      @(posedge clk); #1;
      rbeat = 32'h33; reset_n = 0;
      #1;
      chk("abort_resp", pmem_resp, 0);
      chk("abort_cmd_valid", dram_cmd_valid, 0);
      chk("abort_rdata", pmem_rdata, 0);
      chk("abort_counts", {read_count, write_count}, 0);
      m_rd_cnt = '0; m_wr_cnt = '0; m_rdata = '0;
      pmem_read = 0; rbeat_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("abort_no_resp", pmem_resp, 0);
      @(negedge clk) reset_n = 1;
      @(posedge clk); #1;
      run_txn(1, 0, 16'h0208, '0, {$urandom, $urandom, $urandom, $urandom}, 0);

      for (int i = 0; i < 40; i++) begin
         rd = 1'($urandom_range(0, 1));
         wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
         rl = {$urandom, $urandom, $urandom, $urandom};
         wd = {$urandom, $urandom, $urandom, $urandom};
         run_txn(rd, wr, 16'($urandom), wd, rl, (i % 3 == 0) ? 0 : 1);
         if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
      end

      force dut.read_count_r = 16'hFFFE;
      @(negedge clk);
      release dut.read_count_r;
      @(posedge clk); #1;
      m_rd_cnt = 16'hFFFE;
      chk("preload", read_count, 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         run_txn(1, 0, 16'($urandom), '0, {$urandom, $urandom, $urandom, $urandom}, 0);
      end
      chk("read_count_saturated", read_count, 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
